qrs_detect_mc: RTL

QRS_DETECT_MC -- requirements
Module: qrs_detect_mc

---
 rtl/qrs_detect_mc.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/qrs_detect_mc.sv
// qrs_detect_mc: multi-channel, time-multiplexed QRS / R-peak detector.
//
// Each channel runs INIT -> SEARCH -> QRS -> REFRACT -> SEARCH on its own
// samples. Only the channel addressed by i_ch advances, one sample per cycle.
// An adaptive threshold is seeded from the INIT-phase maximum. It is then
// nudged toward each confirmed peak.
//
// Ports
//   i_clk, i_nrst            clock, asynchronous active-low reset
//   i_ce                     clock enable (state holds, samples ignored when low)
//   i_sample/_valid, i_ch    detection-signal sample, qualifier, channel index
//   i_ctr                    free-running sample counter (wraps)
//   o_rr_period/_valid/_ch   RR interval result, one-cycle strobe, channel
//   o_rpeak_location/_valid  confirmed R-peak counter value and strobe
//   o_rr_reject              RR out of [RR_MIN, RR_MAX] strobe (option only)
//   o_th_initialised         per-channel: threshold has been seeded
//   o_alg_active             per-channel: in QRS or REFRACT
//
// Option macro QRS_DETECT_RR_LIMIT_EN: RR values outside [RR_MIN, RR_MAX] are
// not reported on o_rr_valid; they pulse o_rr_reject instead.
module qrs_detect_mc #(
  parameter int unsigned DATA_WIDTH  = 11,
  parameter int unsigned CTR_WIDTH   = 22,
  parameter int unsigned NCH         = 4,
  parameter int unsigned INIT_LEN    = 512,
  parameter int unsigned QRS_WIN     = 64,
  parameter int unsigned REFRACT_LEN = 200,
  parameter int unsigned TH_SHIFT    = 1,
  parameter int unsigned TH_ALPHA    = 3,
`ifdef QRS_DETECT_RR_LIMIT_EN
  parameter int unsigned RR_MIN      = 60,
  parameter int unsigned RR_MAX      = 600,
`endif
  localparam int unsigned CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_ce,
  input  logic [DATA_WIDTH-1:0] i_sample,
  input  logic                  i_sample_valid,
  input  logic [CH_W-1:0]       i_ch,
  input  logic [CTR_WIDTH-1:0]  i_ctr,
  output logic [CTR_WIDTH-1:0]  o_rr_period,
  output logic                  o_rr_valid,
  output logic [CH_W-1:0]       o_rr_ch,
  output logic [CTR_WIDTH-1:0]  o_rpeak_location,
  output logic                  o_rpeak_valid,
`ifdef QRS_DETECT_RR_LIMIT_EN
  output logic                  o_rr_reject,
`endif
  output logic [NCH-1:0]        o_th_initialised,
  output logic [NCH-1:0]        o_alg_active
);

  localparam int unsigned CNT_W = $clog2(INIT_LEN + 1);
  localparam logic [CNT_W-1:0]     CntLast = CNT_W'(INIT_LEN - 1);
  localparam logic [CTR_WIDTH-1:0] QrsWin  = CTR_WIDTH'(QRS_WIN);
  localparam logic [CTR_WIDTH-1:0] RefrLen = CTR_WIDTH'(REFRACT_LEN);
  localparam logic [CH_W:0]        NchL    = (CH_W + 1)'(NCH);
  localparam logic [DATA_WIDTH:0]  DataMax = {1'b0, {DATA_WIDTH{1'b1}}};

  typedef enum logic [1:0] {StInit, StSearch, StQrs, StRefract} state_e;

  // Per-channel context
  state_e                state_q    [NCH];
  logic [DATA_WIDTH-1:0] th_q       [NCH];
  logic [DATA_WIDTH-1:0] max_q      [NCH];
  logic [DATA_WIDTH-1:0] pk_val_q   [NCH];
  logic [CTR_WIDTH-1:0]  pk_loc_q   [NCH];
  logic [CTR_WIDTH-1:0]  last_loc_q [NCH];
  logic [CTR_WIDTH-1:0]  win_q      [NCH];
  logic [CNT_W-1:0]      cnt_q      [NCH];
  logic                  has_pk_q   [NCH];

  // Output registers
  logic [CTR_WIDTH-1:0] rr_period_q, rpeak_loc_q;
  logic [CH_W-1:0]      rr_ch_q;
  logic                 rr_valid_q, rpeak_valid_q;
`ifdef QRS_DETECT_RR_LIMIT_EN
  logic                 rr_rej_q;
`endif

  logic             ch_ok, upd;
  logic [CH_W-1:0]  ch_idx;

  // Out-of-range channels are dropped; ch_idx stays in range for the reads.
  assign ch_ok  = ({1'b0, i_ch} < NchL);
  assign ch_idx = ch_ok ? i_ch : '0;
  assign upd    = i_ce & i_sample_valid & ch_ok;

  // Addressed channel: current and next context
  state_e                st_cur, st_d;
  logic [DATA_WIDTH-1:0] th_cur, th_d, max_cur, max_d, pk_val_cur, pk_val_d, max_new, th_adapt;
  logic [CTR_WIDTH-1:0]  pk_loc_cur, pk_loc_d, last_cur, last_d, win_cur, win_d;
  logic [CTR_WIDTH-1:0]  win_age, refr_age, rr_period;
  logic [CNT_W-1:0]      cnt_cur, cnt_d;
  logic                  has_pk_cur, has_pk_d;
  logic [DATA_WIDTH:0]   th_sum;
  logic                  rpeak_ev, rr_ev, rr_rej_ev, rr_in_range;

  assign st_cur     = state_q[ch_idx];
  assign th_cur     = th_q[ch_idx];
  assign max_cur    = max_q[ch_idx];
  assign pk_val_cur = pk_val_q[ch_idx];
  assign pk_loc_cur = pk_loc_q[ch_idx];
  assign last_cur   = last_loc_q[ch_idx];
  assign win_cur    = win_q[ch_idx];
  assign cnt_cur    = cnt_q[ch_idx];
  assign has_pk_cur = has_pk_q[ch_idx];

  // Modulo differences: wrap of i_ctr falls out of the fixed-width subtract.
  assign win_age   = i_ctr - win_cur;
  assign refr_age  = i_ctr - pk_loc_cur;
  assign rr_period = pk_loc_cur - last_cur;
  assign max_new   = (i_sample > max_cur) ? i_sample : max_cur;

  // th - th/2^A + (peak/2^S)/2^A, one guard bit, saturated
  assign th_sum   = {1'b0, th_cur} - ({1'b0, th_cur} >> TH_ALPHA)
                  + (({1'b0, pk_val_cur} >> TH_SHIFT) >> TH_ALPHA);
  assign th_adapt = (th_sum > DataMax) ? {DATA_WIDTH{1'b1}} : th_sum[DATA_WIDTH-1:0];

`ifdef QRS_DETECT_RR_LIMIT_EN
  assign rr_in_range = (rr_period >= CTR_WIDTH'(RR_MIN)) && (rr_period <= CTR_WIDTH'(RR_MAX));
`else
  assign rr_in_range = 1'b1;
`endif

  always_comb begin
    st_d      = st_cur;
    th_d      = th_cur;
    max_d     = max_cur;
    pk_val_d  = pk_val_cur;
    pk_loc_d  = pk_loc_cur;
    last_d    = last_cur;
    win_d     = win_cur;
    cnt_d     = cnt_cur;
    has_pk_d  = has_pk_cur;
    rpeak_ev  = 1'b0;
    rr_ev     = 1'b0;
    rr_rej_ev = 1'b0;
    unique case (st_cur)
      StInit: begin
        max_d = max_new;
        cnt_d = cnt_cur + 1'b1;
        if (cnt_cur == CntLast) begin
          th_d = max_new >> TH_SHIFT;
          st_d = StSearch;
        end
      end
      StSearch: begin
        if (i_sample >= th_cur) begin
          st_d     = StQrs;
          pk_val_d = i_sample;
          pk_loc_d = i_ctr;
          win_d    = i_ctr;
        end
      end
      StQrs: begin
        // A sample beyond the window closes it without joining the peak.
        if ((i_sample < th_cur) || (win_age >= QrsWin)) begin
          st_d     = StRefract;
          rpeak_ev = 1'b1;
          th_d     = th_adapt;
          last_d   = pk_loc_cur;
          has_pk_d = 1'b1;
          if (has_pk_cur) begin
            rr_ev     = rr_in_range;
            rr_rej_ev = ~rr_in_range;
          end
        end else if (i_sample > pk_val_cur) begin
          pk_val_d = i_sample;
          pk_loc_d = i_ctr;
        end
      end
      StRefract: begin
        if (refr_age >= RefrLen) st_d = StSearch;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      for (int c = 0; c < NCH; c++) begin
        state_q[c]    <= StInit;
        th_q[c]       <= '0;
        max_q[c]      <= '0;
        pk_val_q[c]   <= '0;
        pk_loc_q[c]   <= '0;
        last_loc_q[c] <= '0;
        win_q[c]      <= '0;
        cnt_q[c]      <= '0;
        has_pk_q[c]   <= 1'b0;
      end
    end else if (upd) begin
      state_q[ch_idx]    <= st_d;
      th_q[ch_idx]       <= th_d;
      max_q[ch_idx]      <= max_d;
      pk_val_q[ch_idx]   <= pk_val_d;
      pk_loc_q[ch_idx]   <= pk_loc_d;
      last_loc_q[ch_idx] <= last_d;
      win_q[ch_idx]      <= win_d;
      cnt_q[ch_idx]      <= cnt_d;
      has_pk_q[ch_idx]   <= has_pk_d;
    end
  end

  // Strobes drop every clock so they never stretch; data holds between strobes.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      rr_period_q   <= '0;
      rr_ch_q       <= '0;
      rr_valid_q    <= 1'b0;
      rpeak_loc_q   <= '0;
      rpeak_valid_q <= 1'b0;
`ifdef QRS_DETECT_RR_LIMIT_EN
      rr_rej_q      <= 1'b0;
`endif
    end else begin
      rr_valid_q    <= upd & rr_ev;
      rpeak_valid_q <= upd & rpeak_ev;
`ifdef QRS_DETECT_RR_LIMIT_EN
      rr_rej_q      <= upd & rr_rej_ev;
`endif
      if (upd & rr_ev) begin
        rr_period_q <= rr_period;
        rr_ch_q     <= ch_idx;
      end
      if (upd & rpeak_ev) rpeak_loc_q <= pk_loc_cur;
    end
  end

  always_comb begin
    o_th_initialised = '0;
    o_alg_active     = '0;
    for (int c = 0; c < NCH; c++) begin
      o_th_initialised[c] = (state_q[c] != StInit);
      o_alg_active[c]     = (state_q[c] == StQrs) || (state_q[c] == StRefract);
    end
  end

  assign o_rr_period      = rr_period_q;
  assign o_rr_valid       = rr_valid_q;
  assign o_rr_ch          = rr_ch_q;
  assign o_rpeak_location = rpeak_loc_q;
  assign o_rpeak_valid    = rpeak_valid_q;
`ifdef QRS_DETECT_RR_LIMIT_EN
  assign o_rr_reject      = rr_rej_q;
`else
  // rr_rej_ev only drives o_rr_reject when the option is built in.
  logic unused_rej;
  assign unused_rej = rr_rej_ev;
`endif

endmodule
